// File: rtl/config_loader.sv
// Byte-stream configuration loader: packs bytes into 32-bit words and strobes one latch-enable per word.
// Optional trailing XOR checksum byte is enabled by defining CONFIG_LOADER_CHECKSUM_EN.
module config_loader #(
   parameter int NUM_WORDS     = 32,
   parameter int STROBE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_start,
   input  logic        io_in_valid,
   input  logic [7:0]  io_in_data,
   output logic        io_in_ready,
   output logic [31:0] io_d_in,
   output logic [31:0] io_configs_en,
   output logic        io_busy,
   output logic        io_done,
   output logic        io_error
);

`ifdef CONFIG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, ASSEMBLE, SETUP, STROBE, HOLD, DONE, CHECK} state_t;
`else
   typedef enum logic [2:0] {IDLE, ASSEMBLE, SETUP, STROBE, HOLD, DONE} state_t;
`endif

   localparam logic [4:0] LAST_WORD = 5'(NUM_WORDS - 1);
   localparam logic [3:0] LAST_STB  = 4'(STROBE_CYCLES - 1);

   state_t      state, state_n;
   logic [1:0]  byte_cnt;
   logic [4:0]  word_idx;
   logic [3:0]  strobe_cnt;
   logic [23:0] word_buf;
   logic        accept;

   // io_in_ready is itself registered from the next state, so it already implies ASSEMBLE/CHECK
   assign accept = io_in_valid & io_in_ready;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (io_start) state_n = ASSEMBLE;
         ASSEMBLE: if (accept && byte_cnt == 2'd3) state_n = SETUP;
         SETUP:    state_n = STROBE;
         STROBE:   if (strobe_cnt == LAST_STB) state_n = HOLD;
         HOLD: begin
            if (word_idx != LAST_WORD) state_n = ASSEMBLE;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            else state_n = CHECK;
`else
            else state_n = DONE;
`endif
         end
`ifdef CONFIG_LOADER_CHECKSUM_EN
         CHECK:    if (accept) state_n = DONE;
`endif
         DONE:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

`ifdef CONFIG_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk) begin
      if (reset) begin
         csum     <= '0;
         io_error <= 1'b0;
      end else begin
         if (state == IDLE && io_start) begin
            csum     <= '0;
            io_error <= 1'b0;
         end else if (state == ASSEMBLE && accept) begin
            csum <= csum ^ io_in_data;
         end else if (state == CHECK && accept) begin
            io_error <= (io_in_data != csum);
         end
      end
   end
`else
   assign io_error = 1'b0;
`endif

   // Partial-word bytes need no reset; io_d_in only ever takes a complete word
   always_ff @(posedge clk) begin
      if (state == ASSEMBLE && accept) begin
         case (byte_cnt)
            2'd0:    word_buf[7:0]   <= io_in_data;
            2'd1:    word_buf[15:8]  <= io_in_data;
            2'd2:    word_buf[23:16] <= io_in_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         word_idx      <= '0;
         strobe_cnt    <= '0;
         io_d_in       <= '0;
         io_configs_en <= '0;
         io_in_ready   <= 1'b0;
         io_busy       <= 1'b0;
         io_done       <= 1'b0;
      end else begin
         state         <= state_n;
         io_in_ready   <= (state_n == ASSEMBLE)
`ifdef CONFIG_LOADER_CHECKSUM_EN
                          || (state_n == CHECK)
`endif
                          ;
         io_busy       <= (state_n != IDLE);
         io_done       <= (state_n == DONE);
         io_configs_en <= (state_n == STROBE) ? (32'd1 << word_idx) : '0;
         case (state)
            IDLE: if (io_start) begin
               byte_cnt <= '0;
               word_idx <= '0;
            end
            ASSEMBLE: if (accept) begin
               byte_cnt <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) io_d_in <= {io_in_data, word_buf};
            end
            SETUP:  strobe_cnt <= '0;
            STROBE: strobe_cnt <= strobe_cnt + 4'd1;
            HOLD:   if (word_idx != LAST_WORD) word_idx <= word_idx + 5'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: transaction-level expected-output model compared every cycle,
// plus literal single-word, checksum, stall and mid-strobe reset scenarios.
module tb_config_loader;

   localparam int N = 32;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        io_start = 1'b0, io_in_valid = 1'b0;
   logic [7:0]  io_in_data = '0;
   logic        io_in_ready, io_busy, io_done, io_error;
   logic [31:0] io_d_in, io_configs_en;

   logic        s_start = 1'b0, s_valid = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_ready, s_busy, s_done, s_err;
   logic [31:0] s_d, s_en;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   config_loader #(.NUM_WORDS(N), .STROBE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .io_start(io_start), .io_in_valid(io_in_valid),
      .io_in_data(io_in_data), .io_in_ready(io_in_ready), .io_d_in(io_d_in),
      .io_configs_en(io_configs_en), .io_busy(io_busy), .io_done(io_done), .io_error(io_error));

   config_loader #(.NUM_WORDS(1), .STROBE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .io_start(s_start), .io_in_valid(s_valid),
      .io_in_data(s_data), .io_in_ready(s_ready), .io_d_in(s_d),
      .io_configs_en(s_en), .io_busy(s_busy), .io_done(s_done), .io_error(s_err));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Expected outputs derived from the load schedule: t counts cycles since a word's 4th byte
   int          ph = 0, nb = 0, w = 0, t = 0;
   logic [31:0] mbuf = '0, e_d = '0, e_en = '0, d_hold = '0;
   logic [7:0]  mx = '0;
   logic        e_ready = 0, e_busy = 0, e_done = 0, e_err = 0;

   always @(negedge clk) begin : model
      int nph, nnb, nw, nt;
      logic [31:0] nbuf, nd, nen;
      logic [7:0]  nx;
      logic        nready, nbusy, ndone, nerr;
      chk("ready", 32'(io_in_ready), 32'(e_ready));
      chk("busy", 32'(io_busy), 32'(e_busy));
      chk("done", 32'(io_done), 32'(e_done));
      chk("error", 32'(io_error), 32'(e_err));
      chk("d_in", io_d_in, e_d);
      chk("configs_en", io_configs_en, e_en);
      chk("en_multi_hot", 32'($countones(io_configs_en) > 1), 32'd0);
      if (ph == 2 && t >= 2) chk("d_in_stable", io_d_in, d_hold);
      nph = ph; nnb = nb; nw = w; nt = t; nbuf = mbuf; nd = e_d; nen = e_en; nx = mx;
      nready = e_ready; nbusy = e_busy; ndone = e_done; nerr = e_err;
      if (reset) begin
         nph = 0; nnb = 0; nw = 0; nt = 0; nd = '0; nen = '0; nx = '0;
         nready = 0; nbusy = 0; ndone = 0; nerr = 0;
      end else begin
         case (ph)
            0: if (io_start) begin
               nph = 1; nnb = 0; nw = 0; nx = '0; nerr = 0; nready = 1; nbusy = 1;
            end
            1: if (io_in_valid) begin
               nbuf[8*nb +: 8] = io_in_data;
               nx = mx ^ io_in_data;
               nnb = nb + 1;
               if (nnb == 4) begin
                  nph = 2; nt = 1; nd = nbuf; nready = 0;
               end
            end
            2: begin
               nt = t + 1;
               if (nt <= 1 + S) nen = 32'd1 << w;
               else if (nt == 2 + S) nen = '0;
               else begin
                  nt = 0;
                  if (w < N - 1) begin
                     nw = w + 1; nnb = 0; nph = 1; nready = 1;
                  end else begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                     nph = 3; nready = 1;
`else
                     nph = 4; ndone = 1;
`endif
                  end
               end
            end
            3: if (io_in_valid) begin
               nerr = (io_in_data != mx); nready = 0; nph = 4; ndone = 1;
            end
            default: begin
               ndone = 0; nbusy = 0; nph = 0;
            end
         endcase
      end
      if (nph == 2 && nt == 1) d_hold <= nd;
      ph <= nph; nb <= nnb; w <= nw; t <= nt; mbuf <= nbuf; e_d <= nd; e_en <= nen; mx <= nx;
      e_ready <= nready; e_busy <= nbusy; e_done <= ndone; e_err <= nerr;
   end

   int en_cnt[32];
   int done_cnt = 0;
   initial for (int b = 0; b < 32; b++) en_cnt[b] = 0;
   always @(negedge clk) begin
      for (int b = 0; b < 32; b++) if (io_configs_en[b]) en_cnt[b] <= en_cnt[b] + 1;
      if (io_done) done_cnt <= done_cnt + 1;
   end

   task automatic pulse_start();
      io_start = 1'b1;
      @(posedge clk); #1;
      io_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc = 0;
      io_in_valid = 1'b1;
      io_in_data  = b;
      for (int g = 0; g < 50 && !acc; g++) begin
         @(negedge clk);
         acc = io_in_ready;
         @(posedge clk); #1;
      end
      chk("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int g = 0; g < 40 && !seen; g++) begin
         @(posedge clk); #1;
         seen = io_done;
      end
      chk("done_timeout", 32'(seen), 32'd1);
   endtask

   task automatic load1(input logic [31:0] word, input logic [7:0] cbyte, input logic exp_err);
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("s_ready_assemble", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s_data = word[8*k +: 8];
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      chk("s_d_setup", s_d, word);
      chk("s_en_setup", s_en, 32'd0);
      @(posedge clk); #1;
      chk("s_en_strobe", s_en, 32'h1);
      @(posedge clk); #1;
      chk("s_en_hold", s_en, 32'd0);
      chk("s_d_hold", s_d, word);
      @(posedge clk); #1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      chk("s_ready_check", 32'(s_ready), 32'd1);
      chk("s_done_early", 32'(s_done), 32'd0);
      s_valid = 1'b1;
      s_data  = cbyte;
      @(posedge clk); #1;
      s_valid = 1'b0;
`endif
      chk("s_done", 32'(s_done), 32'd1);
      chk("s_error", 32'(s_err), 32'(exp_err));
      @(posedge clk); #1;
      chk("s_done_pulse", 32'(s_done), 32'd0);
      chk("s_busy_idle", 32'(s_busy), 32'd0);
      chk("s_d_retained", s_d, word);
      chk("s_error_sticky", 32'(s_err), 32'(exp_err));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int snap[32];
      int dsnap;
      logic [7:0] cx;
      bit found;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 32'(io_busy), 32'd0);
      chk("rst_ready", 32'(io_in_ready), 32'd0);
      chk("rst_en", io_configs_en, 32'd0);
      chk("rst_d", io_d_in, 32'd0);
      chk("rst_done", 32'(io_done), 32'd0);
      chk("rst_error", 32'(io_error), 32'd0);

      // Full load, byte i = i; a stray start mid-load must be ignored
      for (int b = 0; b < 32; b++) snap[b] = en_cnt[b];
      dsnap = done_cnt;
      pulse_start();
      for (int i = 0; i < 128; i++) begin
         if (i == 50) io_start = 1'b1;
         send_byte(8'(i));
         io_start = 1'b0;
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      send_byte(8'h00);
`endif
      io_in_valid = 1'b0;
      wait_done();
      chk("full_word31", io_d_in, 32'h7F7E7D7C);
      chk("full_error", 32'(io_error), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      for (int b = 0; b < 32; b++) chk($sformatf("en_walk_bit%0d", b), 32'(en_cnt[b] - snap[b]), 32'(S));
      chk("full_done_count", 32'(done_cnt - dsnap), 32'd1);

      // Stall of five cycles between the 2nd and 3rd byte
      pulse_start();
      cx = '0;
      for (int i = 0; i < 128; i++) begin
         if (i == 2) begin
            io_in_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("stall_ready", 32'(io_in_ready), 32'd1);
               chk("stall_en", io_configs_en, 32'd0);
               @(posedge clk); #1;
            end
         end
         cx = cx ^ 8'(i * 3 + 1);
         send_byte(8'(i * 3 + 1));
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      send_byte(cx);
`endif
      io_in_valid = 1'b0;
      wait_done();
      chk("stall_word31", io_d_in, 32'h7E7B7875);
      chk("stall_error", 32'(io_error), 32'd0);
      @(posedge clk); #1;

      // Reset (with a simultaneous start) during STROBE of word 5, then reload
      pulse_start();
      for (int i = 0; i < 24; i++) send_byte(8'(i));
      io_in_valid = 1'b0;
      found = 0;
      for (int g = 0; g < 40 && !found; g++) begin
         if (io_configs_en == 32'h20) found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("word5_strobe_seen", 32'(found), 32'd1);
      reset = 1'b1;
      io_start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      io_start = 1'b0;
      chk("abort_en", io_configs_en, 32'd0);
      chk("abort_busy", 32'(io_busy), 32'd0);
      chk("abort_ready", 32'(io_in_ready), 32'd0);
      pulse_start();
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      io_in_valid = 1'b0;
      found = 0;
      for (int g = 0; g < 10 && !found; g++) begin
         @(posedge clk); #1;
         found = (io_configs_en != 0);
      end
      chk("reload_first_en", io_configs_en, 32'h1);
      chk("reload_word0", io_d_in, 32'hDDCCBBAA);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Single-word loader: literal timing and checksum cases
      load1(32'h12345678, 8'h08, 1'b0);
      load1(32'h08040201, 8'h0F, 1'b0);
`ifdef CONFIG_LOADER_CHECKSUM_EN
      load1(32'h08040201, 8'h0E, 1'b1);
      load1(32'h08040201, 8'h0F, 1'b0);
`else
      load1(32'h08040201, 8'h0E, 1'b0);
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
